// File: rtl/ram_ctrl_pkg.sv
// Shared constants and state encoding for the RAM burst controller.
// Geometry matches the 512 x 32 single-port ram.
package ram_ctrl_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 10;
    localparam int RAM_DEPTH = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } burst_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry fall-through read buffer with simultaneous push/pop.
// An incoming word bypasses storage when the buffer is empty and drained.
module rd_skid_fifo #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wp;
    logic          rp;
    logic          has;
    logic          push;
    logic          pop;

    assign has       = (count != 2'd0);
    assign out_valid = has || in_valid;
    assign out_data  = has      ? mem[rp] :
                       in_valid ? in_data : '0;

    assign pop  = has && out_ready;
    assign push = in_valid && !(!has && out_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the 512 x 32 single-port ram.
// RAM_BURST_WRAP_EN: bursts crossing 511 wrap to 0 instead of being rejected.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wEn,
    output logic [DATA_W-1:0] ram_wDat,
    output logic              ram_rEn,
    input  logic [DATA_W-1:0] ram_rDat
);

    burst_state_t      st;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  dcnt;
    logic              inflight;
    logic              done_q;
    logic              err_q;
    logic              accept;
    logic              bad;
    logic              wen;
    logic              ren;
    logic              pop;
    logic [1:0]        fcount;
    logic [2:0]        occ;

    assign accept = cmd_valid && cmd_ready;

`ifdef RAM_BURST_WRAP_EN
    assign bad = (cmd_len == '0);
`else
    logic [LEN_W:0] span;
    assign span = (LEN_W+1)'(cmd_addr) + (LEN_W+1)'(cmd_len);
    assign bad  = (cmd_len == '0) ||
                  (span > (LEN_W+1)'(RAM_DEPTH));
`endif

    assign cmd_ready = (st == ST_IDLE);
    assign busy      = !cmd_ready;
    assign wr_ready  = (st == ST_WRITE);
    assign wen       = wr_ready && wr_valid;

    // Occupancy counts the word still in the RAM pipe, so two is a hard cap.
    assign occ = {1'b0, fcount} + {2'b0, inflight};
    assign pop = rd_valid && rd_ready;
    assign ren = (st == ST_READ) && (cnt != '0) &&
                 ((occ - {2'b0, pop}) < 3'd2);

    assign ram_wEn  = wen;
    assign ram_rEn  = ren;
    assign ram_wDat = wen ? wr_data : '0;
    assign ram_addr = (wen || ren) ? addr : last_addr;

    assign rd_last = rd_valid && (dcnt == LEN_W'(1));
    assign done    = done_q;
    assign err     = err_q;

    rd_skid_fifo #(
        .DW(DATA_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .in_valid (inflight),
        .in_data  (ram_rDat),
        .out_valid(rd_valid),
        .out_ready(rd_ready),
        .out_data (rd_data),
        .count    (fcount)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            addr      <= '0;
            last_addr <= '0;
            cnt       <= '0;
            dcnt      <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inflight <= ren;
            if (wen || ren) begin
                last_addr <= addr;
                addr      <= addr + 1'b1;
            end
            unique case (st)
                ST_IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            err_q <= 1'b1;
                        end else begin
                            addr <= cmd_addr;
                            cnt  <= cmd_len;
                            dcnt <= cmd_len;
                            st   <= cmd_write ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wen) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            st     <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (ren) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (pop) begin
                        dcnt <= dcnt - 1'b1;
                        if (dcnt == LEN_W'(1)) begin
                            st     <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 512 x 32 ram.
// Command table plus hand sequences for reset and back-to-back bursts.
module tb_ram_burst_ctrl;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [8:0]  cmd_addr;
    logic [9:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  ram_addr;
    logic        ram_wEn;
    logic [31:0] ram_wDat;
    logic        ram_rEn;
    logic [31:0] ram_rDat;

    logic [31:0] ram    [512];
    logic [31:0] expmem [512];

    int total;
    int bad;

    typedef struct {
        logic        wr;
        logic [8:0]  a;
        logic [9:0]  len;
        logic [31:0] base;
        int          mode;
        logic        exp_err;
    } vec_t;

    ram_burst_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ram_addr (ram_addr),
        .ram_wEn  (ram_wEn),
        .ram_wDat (ram_wDat),
        .ram_rEn  (ram_rEn),
        .ram_rDat (ram_rDat)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous ram: one-cycle read latency, output holds last read.
    always @(posedge clock) begin
        if (ram_wEn) ram[ram_addr] <= ram_wDat;
        if (ram_rEn) ram_rDat <= ram[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic w, input logic [8:0] a,
                             input logic [9:0] len);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        #1 chk1("cmd_ready", cmd_ready, 1'b1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic run_err(input vec_t v);
        int strobes;
        strobes = 0;
        issue_cmd(v.wr, v.a, v.len);
        #1;
        chk1("err_pulse", err, 1'b1);
        chk1("err_busy", busy, 1'b0);
        strobes += int'(ram_wEn) + int'(ram_rEn);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            if (i == 0) chk1("err_once", err, 1'b0);
            strobes += int'(ram_wEn) + int'(ram_rEn);
        end
        chk("err_no_access", strobes, 0);
    endtask

    task automatic run_burst(input vec_t v);
        int          beats, got, issued, done_it, hs_it, viol;
        bit          done_seen, pop;
        logic [8:0]  ea;
        beats = 0; got = 0; issued = 0; viol = 0;
        done_it = -1; hs_it = -9; done_seen = 0;
        if (v.wr) begin
            for (int j = 0; j < int'(v.len); j++) begin
                ea = v.a + 9'(j);
                expmem[ea] = v.base + 32'(j);
            end
        end
        issue_cmd(v.wr, v.a, v.len);
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (i > 0) @(negedge clock);
            wr_valid = v.wr;
            wr_data  = v.base + 32'(beats);
            case (v.mode)
                1:       rd_ready = (i % 2) == 1;
                2:       rd_ready = !(i >= 2 && i < 7);
                default: rd_ready = 1'b1;
            endcase
            #1;
            if (i == 0) begin
                chk1("busy", busy, 1'b1);
                if (v.wr) chk1("first_wr_ready", wr_ready, 1'b1);
                else      chk1("first_rEn", ram_rEn, 1'b1);
            end
            if (!v.wr && v.mode == 0 && i < 2)
                chk1("rd_valid_latency", rd_valid, i == 1);
            if (ram_wEn && ram_rEn) viol++;
            if (ram_wEn) begin
                ea = v.a + 9'(beats);
                chk("wr_addr", int'(ram_addr), int'(ea));
                chk("wr_dat", int'(ram_wDat), int'(v.base + 32'(beats)));
                beats++;
                hs_it = i;
            end
            pop = rd_valid && rd_ready;
            if (ram_rEn) begin
                ea = v.a + 9'(issued);
                chk("rd_addr", int'(ram_addr), int'(ea));
                if (issued - got - int'(pop) >= 2) viol++;
                issued++;
            end
            if (pop) begin
                ea = v.a + 9'(got);
                chk("rd_data", int'(rd_data), int'(expmem[ea]));
                chk1("rd_last", rd_last, got == int'(v.len) - 1);
                got++;
                hs_it = i;
            end
            if (done) begin
                done_seen = 1;
                done_it   = i;
                chk1("done_cmd_ready", cmd_ready, 1'b1);
                chk1("done_busy", busy, 1'b0);
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk1("done_seen", done_seen, 1'b1);
        chk("done_timing", done_it, hs_it + 1);
        chk("word_count", v.wr ? beats : got, int'(v.len));
        if (!v.wr) chk("issue_count", issued, int'(v.len));
        chk("strobe_viol", viol, 0);
    endtask

    task automatic run(input vec_t v);
        if (v.exp_err) run_err(v);
        else           run_burst(v);
    endtask

    initial begin
        vec_t tbl [10];
        vec_t v;
        int   got, nb, dn;
        bit   seen;
        logic [8:0] ea;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 512; i++) begin
            ram[i]    = '0;
            expmem[i] = '0;
        end
        ram_rDat  = '0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        tbl[0] = '{1'b1, 9'h010, 10'd4, 32'hA0, 0, 1'b0};
        tbl[1] = '{1'b0, 9'h010, 10'd4, 32'h0,  0, 1'b0};
        tbl[2] = '{1'b0, 9'h010, 10'd4, 32'h0,  1, 1'b0};
        tbl[3] = '{1'b0, 9'h010, 10'd4, 32'h0,  2, 1'b0};
        tbl[4] = '{1'b1, 9'h020, 10'd0, 32'h0,  0, 1'b1};
`ifdef RAM_BURST_WRAP_EN
        tbl[5] = '{1'b1, 9'h1FE, 10'd4, 32'hB0, 0, 1'b0};
        tbl[6] = '{1'b0, 9'h1FE, 10'd4, 32'h0,  0, 1'b0};
`else
        tbl[5] = '{1'b1, 9'h1FE, 10'd4, 32'hB0, 0, 1'b1};
        tbl[6] = '{1'b0, 9'h1FE, 10'd4, 32'h0,  0, 1'b1};
`endif
        tbl[7] = '{1'b1, 9'h100, 10'd8, 32'hC0, 0, 1'b0};
        tbl[8] = '{1'b0, 9'h100, 10'd1, 32'h0,  0, 1'b0};
        tbl[9] = '{1'b0, 9'h100, 10'd8, 32'h0,  2, 1'b0};

        @(negedge clock);
        @(negedge clock);
        #1;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk1("rst_rd_last", rd_last, 1'b0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_wEn", ram_wEn, 1'b0);
        chk1("rst_rEn", ram_rEn, 1'b0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wDat", int'(ram_wDat), 0);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            v = tbl[k];
            run(v);
        end

        // Reset while the third word of an 8-word read is on offer.
        issue_cmd(1'b0, 9'h100, 10'd8);
        rd_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 2; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            if (rd_valid && rd_ready) got++;
        end
        chk("pre_reset_words", got, 2);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk1("mid_rst_rd_valid", rd_valid, 1'b0);
        chk1("mid_rst_rEn", ram_rEn, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        rd_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            dn += int'(done);
            @(negedge clock);
        end
        chk("mid_rst_no_done", dn, 0);
        v = '{1'b0, 9'h100, 10'd8, 32'h0, 0, 1'b0};
        run(v);

        // Write then read with cmd_valid held across the write's done cycle.
        expmem[9'h060] = 32'hD0;
        expmem[9'h061] = 32'hD1;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 9'h060;
        cmd_len   = 10'd2;
        wr_valid  = 1'b1;
        wr_data   = 32'hD0;
        @(negedge clock);
        cmd_write = 1'b0;
        nb   = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (i > 0) @(negedge clock);
            wr_data = 32'hD0 + 32'(nb);
            #1;
            if (ram_wEn) nb++;
            if (done) begin
                seen = 1;
                chk1("b2b_ready_in_done", cmd_ready, 1'b1);
            end
        end
        chk1("b2b_write_done", seen, 1'b1);
        chk("b2b_beats", nb, 2);
        @(negedge clock);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b1;
        got  = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            if (i == 0) chk1("b2b_read_busy", busy, 1'b1);
            if (rd_valid && rd_ready) begin
                ea = 9'h060 + 9'(got);
                chk("b2b_rd_data", int'(rd_data), int'(expmem[ea]));
                got++;
            end
            if (done) seen = 1;
        end
        chk("b2b_read_words", got, 2);
        chk1("b2b_read_done", seen, 1'b1);
        rd_ready = 1'b0;

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst initiator for the 512 x 32 synchronous single-port `ram`. It accepts one read or write burst command at a time and turns it into per-cycle `wEn`/`rEn` strobes with an incrementing address. Write data streams in and read data streams out over valid/ready handshakes. It sits between datapath clients and the RAM, and it absorbs the RAM's one-cycle read latency and hold-last-read behaviour so that downstream backpressure never loses data.

## Interface
- `ADDR_W`, 9, RAM address width (depth 2^ADDR_W = 512)
- `DATA_W`, 32, word width
- `LEN_W`, 10, burst length field width (1..512 words)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_write` in 1: 1 = write burst, 0 = read burst
- `cmd_addr` in ADDR_W: start address
- `cmd_len` in LEN_W: word count
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DATA_W: write stream
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out DATA_W / `rd_last` out 1: read stream
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse on burst completion
- `err` out 1: one-cycle pulse on command rejection
- `ram_addr` out ADDR_W / `ram_wEn` out 1 / `ram_wDat` out DATA_W / `ram_rEn` out 1 / `ram_rDat` in DATA_W: RAM port

## Operation
- States: IDLE, WRITE, READ.
- IDLE: `cmd_ready`=1. A command is accepted on `cmd_valid && cmd_ready`, which latches addr, remaining count (=len) and direction.
- Command rejection: `cmd_len`==0 is accepted but not executed. It causes `err` to pulse next cycle and the block stays in IDLE.
- WRITE: `wr_ready`=1. Each `wr_valid && wr_ready` cycle does the following:
  - `ram_wEn`=1, with `ram_addr`=current addr and `ram_wDat`=`wr_data`, combinationally.
  - addr+1 (mod 512), count-1.
  - The last beat moves the block to IDLE.
- READ issue: `ram_rEn` asserts when the issue count is nonzero and (buffered + in-flight − popping) < 2. Each issue does addr+1 and issue count-1.
- READ capture: `ram_rDat` is captured into a 2-entry output buffer on the cycle after an issue. `rd_valid` = buffer non-empty.
- READ exit: `rd_last` is asserted with the final word. The block returns to IDLE after the final `rd_valid && rd_ready`.
- `ram_wEn` and `ram_rEn` are never both 1.
- Outside WRITE/READ issue, all `ram_*` strobes are 0 and `ram_addr` holds its last value.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - state IDLE; buffer empty; counters 0; addr 0.
  - `cmd_ready`=1; `wr_ready`=0; `rd_valid`=0; `rd_last`=0; `rd_data`=0.
  - `busy`=0; `done`=0; `err`=0.
  - `ram_wEn`=0; `ram_rEn`=0; `ram_addr`=0; `ram_wDat`=0.
- Reset mid-burst: strobes drop immediately (asynchronous), buffered data is discarded, and no `done` is produced. Words already written stay in the RAM.
- Command accepted at edge E0: the first `wr_ready` or `ram_rEn` is in cycle E0+1. The earliest `rd_valid` is in cycle E0+2.
- Throughput is 1 word/cycle both directions with no backpressure.
- Read backpressure: with `rd_ready`=0, at most 2 words are outstanding and the RAM is not re-read. Data must not be lost or duplicated.
- `done` pulses in the cycle after the final data handshake. `cmd_ready` is 1 in that same cycle, so back-to-back commands lose one idle cycle only.
- Address arithmetic is modulo 2^ADDR_W. The count is LEN_W bits wide.

## Configuration
- `RAM_BURST_WRAP_EN` defined: a burst crossing address 511 wraps to 0 and continues.
- `RAM_BURST_WRAP_EN` undefined: a command with addr+len > 512 is rejected like len==0 (`err` pulse, no RAM access, stays IDLE).

## Structure
- Package `ram_ctrl_pkg` holds:
  - ADDR_W, DATA_W, LEN_W, RAM_DEPTH=512
  - state enum `burst_state_t`
- Sub-module `rd_skid_fifo`: 2-entry valid/ready buffer with simultaneous push/pop, exposing count for the issue throttle.

## Test plan
- Write burst addr=0x010, len=4, data 0xA0..0xA3, `wr_valid` steady → `ram_wEn` on 4 consecutive cycles at 0x010..0x013; `done` 1 cycle after the last beat.
- Read back addr=0x010, len=4, `rd_ready`=1 → `rd_data` 0xA0..0xA3 on consecutive cycles starting E0+2; `rd_last` on 0xA3.
- Same read with `rd_ready` toggling 1/0 every cycle, and held low for 5 cycles mid-burst → all 4 words delivered in order exactly once; `ram_rEn` never issues with 2 words outstanding.
- Command len=0 → `err` pulse, no `ram_*` strobes; addr=0x1FE, len=4 → with WRAP_EN, writes hit 0x1FE, 0x1FF, 0x000, 0x001; without WRAP_EN, `err` pulse and no access.
- Assert `reset` during word 2 of an 8-word read → `rd_valid` and `ram_rEn` go 0 immediately; no `done`; the next command executes normally.
- Back-to-back write then read commands with `cmd_valid` held → second accepted in the `done` cycle; read returns the just-written data.
